// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined two's-complement adder/subtractor. WIDTH-bit operands are cut
//   into CHUNK-bit slices; stage k resolves slice k and registers its carry
//   for stage k+1. The not-yet-processed upper operand bits travel down the
//   pipe with the transaction, and finished lower result bits are carried
//   forward, so every stage holds exactly one transaction.
//
//   Latency is STAGES clocks: operands presented before edge N are captured
//   by stage 0 on edge N, and the result is valid after edge N+STAGES-1,
//   i.e. STAGES cycles after the operands were driven. Throughput is one
//   transaction per clock.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (in_ready = !out_valid | out_ready)
//   a, b, m         operands and mode (0 = a+b, 1 = a-b)
//   out_valid/ready result handshake
//   s               result modulo 2^WIDTH
//   carry           carry out of MSB (subtract: 1 = no borrow)
//   overflow        signed overflow
//   zero            s == 0
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    // The whole pipe moves or holds as one; bubbles are not squeezed out.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int UP = WIDTH - k * CHUNK;   // operand bits still to process
        localparam int LO = k * CHUNK;           // result bits already resolved

        logic [UP-1:0]      a_rem;
        logic [UP-1:0]      b_rem;
        logic               c_in;
        logic               v_in;
        logic [CHUNK:0]     sum;
        logic [LO+CHUNK-1:0] s_nxt;
        logic [LO+CHUNK-1:0] s_q;
        logic               c_q;
        logic               v_q;

        if (k == 0) begin : g_first
            // Subtraction: invert b here and feed m in as the carry.
            assign a_rem = a;
            assign b_rem = b ^ {WIDTH{m}};
            assign c_in  = m;
            assign v_in  = in_valid;
            assign s_nxt = sum[CHUNK-1:0];
        end else begin : g_next
            assign a_rem = g_stage[k-1].g_fwd.a_q;
            assign b_rem = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign s_nxt = {sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign sum = {1'b0, a_rem[CHUNK-1:0]} + {1'b0, b_rem[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= sum[CHUNK];
                s_q <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UP-CHUNK-1:0] a_q;
            logic [UP-CHUNK-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_rem[UP-1:CHUNK];
                    b_q <= b_rem[UP-1:CHUNK];
                end
            end
        end else begin : g_last
            // Carry into the MSB comes from adding the slice without its top bit.
            logic [CHUNK-1:0] low;
            logic             ovf_q;
            logic             zero_q;

            assign low = {1'b0, a_rem[CHUNK-2:0]} + {1'b0, b_rem[CHUNK-2:0]}
                       + {{(CHUNK-1){1'b0}}, c_in};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= low[CHUNK-1] ^ sum[CHUNK];
                    zero_q <= (s_nxt == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].s_q;
    assign carry     = g_stage[STAGES-1].c_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
    assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        carry;
    logic        overflow;
    logic        zero;

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pop    = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    bit bp_mode  = 0;

    // {carry, overflow, zero, s}
    logic [18:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] model(input logic [15:0] a_i, input logic [15:0] b_i,
                                          input logic m_i);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] low15;
        bb    = m_i ? ~b_i : b_i;
        full  = {1'b0, a_i} + {1'b0, bb} + {16'd0, m_i};
        low15 = {1'b0, a_i[14:0]} + {1'b0, bb[14:0]} + {15'd0, m_i};
        return {full[16], low15[15] ^ full[16], full[15:0] == 16'd0, full[15:0]};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard, handshake relation, stall stability.
    logic        stall_prev = 1'b0;
    logic [19:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rel", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_prev)
                check("hold", 32'({out_valid, carry, overflow, zero, s}), 32'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(1), 32'(0));
                end else begin
                    logic [18:0] e;
                    e = sb.pop_front();
                    check("s", 32'(s), 32'(e[15:0]));
                    check("carry", 32'(carry), 32'(e[18]));
                    check("overflow", 32'(overflow), 32'(e[17]));
                    check("zero", 32'(zero), 32'(e[16]));
                    if (n_pop == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n_pop++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_valid, carry, overflow, zero, s};
        end
    end

    task automatic send(input logic [15:0] a_i, input logic [15:0] b_i, input logic m_i,
                        input logic [18:0] exp);
        bit done;
        done = 0;
        a = a_i; b = b_i; m = m_i; in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); m = 1'($urandom);
        if (!done) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_rand(input logic m_i);
        logic [15:0] x;
        logic [15:0] y;
        x = 16'($urandom);
        y = 16'($urandom);
        send(x, y, m_i, model(x, y, m_i));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1 Reset with random inputs
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            m = 1'($urandom); out_ready = 1'($urandom);
            #2;
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_flags", 32'({s, carry, overflow, zero}), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_out_valid", 32'(out_valid), 32'(0));
        end

        // 2 Add with latency check: result visible after the 4th edge from driving
        send(16'h1234, 16'h0FCD, 1'b0, {1'b0, 1'b0, 1'b0, 16'h2201});
        check("lat_edge1", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_edge2", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_edge3", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_edge4", 32'(out_valid), 32'(1));
        drain();

        // 3 Subtract / boundary cases
        send(16'h0003, 16'h0005, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
        send(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});
        send(16'hABCD, 16'hABCD, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});
        send(16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
        send(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
        send(16'h0000, 16'h0001, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFF});
        drain();

        // 4 Back-to-back streaming, alternating mode
        n_pop = 0;
        for (int i = 0; i < 20; i++) send_rand(1'(i % 2));
        drain();
        check("stream_count", 32'(n_pop), 32'(20));
        check("stream_consecutive", 32'(last_cyc - first_cyc), 32'(19));

        // 5 Back-pressure with random bubbles
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_rand(1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        bp_mode = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // 6 Reset with transactions in flight
        out_ready = 1'b0;
        send_rand(1'b0);
        send_rand(1'b1);
        send_rand(1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'(0));
        check("rst_mid_s", 32'(s), 32'(0));
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", 32'(out_valid), 32'(0));
        end

        // Pipe still works after the mid-flight reset
        send(16'h00FF, 16'h0F01, 1'b0, model(16'h00FF, 16'h0F01, 1'b0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
